sram_arb: RTL and testbench

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_arb.sv | 117 +++++++++++
 tb/tb_sram_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb.sv
// Round-robin arbiter multiplexing NUM_PORTS requesters onto one SRAM port.
// Combinational grant; in-flight reads are tracked to return rvalid/rdata.
module sram_arb #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024,
  parameter int OUT_REGS   = 0,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int BW = (DATA_WIDTH + 7) / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_PORTS-1:0]                 req_i,
  output logic [NUM_PORTS-1:0]                 gnt_o,
  input  logic [NUM_PORTS-1:0]                 we_i,
  input  logic [NUM_PORTS-1:0][AW-1:0]         addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS-1:0][BW-1:0]         be_i,
  output logic [NUM_PORTS-1:0]                 rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [AW-1:0]                        sram_addr_o,
  output logic [DATA_WIDTH-1:0]                sram_wdata_o,
  output logic [BW-1:0]                        sram_be_o,
  input  logic [DATA_WIDTH-1:0]                sram_rdata_i
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int RL = 1 + OUT_REGS;

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
    $error("sram_arb: NUM_PORTS must be 2..8");
  end
  if (OUT_REGS < 0 || OUT_REGS > 1) begin : g_bad_oregs
    $error("sram_arb: OUT_REGS must be 0 or 1");
  end

  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         win;
  logic [PW-1:0]         cand;
  logic                  found;
  logic                  hit;
  logic [RL-1:0]         rv_q;
  logic [RL-1:0][PW-1:0] rp_q;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign hit = found & ~rst_i;

  always_comb begin
    gnt_o = '0;
    if (hit) gnt_o[win] = 1'b1;
  end

  always_comb begin
    sram_req_o   = hit;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (hit) begin
      sram_we_o    = we_i[win];
      sram_addr_o  = addr_i[win];
      sram_wdata_o = wdata_i[win];
      sram_be_o    = be_i[win];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (hit) begin
      ptr_q <= (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
    end
  end

  // Read-return pipeline: one stage per cycle of SRAM latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rv_q <= '0;
      rp_q <= '0;
    end else begin
      rv_q[0] <= hit & ~we_i[win];
      rp_q[0] <= win;
      for (int i = 1; i < RL; i++) begin
        rv_q[i] <= rv_q[i-1];
        rp_q[i] <= rp_q[i-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (rv_q[RL-1] && !rst_i) rvalid_o[rp_q[RL-1]] = 1'b1;
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rvalid_o[p]) rdata_o[p] = sram_rdata_i;
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: three configurations, each with a
// behavioural SRAM model (byte-enable writes, 1- or 2-cycle reads).
module tb_sram_arb;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int pass  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
    else pass++;
  endtask

  function automatic logic [63:0] bmerge(logic [63:0] o, logic [63:0] n,
                                         logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // ---------------- A: 2 ports, RL=1 ----------------
  logic             a_rst;
  logic [1:0]       a_req, a_gnt, a_we, a_rv;
  logic [1:0][3:0]  a_addr;
  logic [1:0][63:0] a_wd, a_rd;
  logic [1:0][7:0]  a_be;
  logic             a_sreq, a_swe;
  logic [3:0]       a_saddr;
  logic [63:0]      a_swd, a_srd;
  logic [7:0]       a_sbe;
  logic [63:0]      mem_a [16];

  sram_arb #(.NUM_PORTS(2), .DATA_WIDTH(64), .NUM_WORDS(16), .OUT_REGS(0)) u_a (
    .clk_i(clk), .rst_i(a_rst), .req_i(a_req), .gnt_o(a_gnt), .we_i(a_we),
    .addr_i(a_addr), .wdata_i(a_wd), .be_i(a_be), .rvalid_o(a_rv),
    .rdata_o(a_rd), .sram_req_o(a_sreq), .sram_we_o(a_swe),
    .sram_addr_o(a_saddr), .sram_wdata_o(a_swd), .sram_be_o(a_sbe),
    .sram_rdata_i(a_srd));

  always @(posedge clk) if (a_sreq) begin
    if (a_swe) mem_a[a_saddr] <= bmerge(mem_a[a_saddr], a_swd, a_sbe);
    else a_srd <= mem_a[a_saddr];
  end

  // ---------------- B: 2 ports, RL=2 ----------------
  logic             b_rst;
  logic [1:0]       b_req, b_gnt, b_we, b_rv;
  logic [1:0][3:0]  b_addr;
  logic [1:0][63:0] b_wd, b_rd;
  logic [1:0][7:0]  b_be;
  logic             b_sreq, b_swe;
  logic [3:0]       b_saddr;
  logic [63:0]      b_swd, b_s0, b_srd;
  logic [7:0]       b_sbe;
  logic [63:0]      mem_b [16];

  sram_arb #(.NUM_PORTS(2), .DATA_WIDTH(64), .NUM_WORDS(16), .OUT_REGS(1)) u_b (
    .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .gnt_o(b_gnt), .we_i(b_we),
    .addr_i(b_addr), .wdata_i(b_wd), .be_i(b_be), .rvalid_o(b_rv),
    .rdata_o(b_rd), .sram_req_o(b_sreq), .sram_we_o(b_swe),
    .sram_addr_o(b_saddr), .sram_wdata_o(b_swd), .sram_be_o(b_sbe),
    .sram_rdata_i(b_srd));

  always @(posedge clk) begin
    if (b_sreq) begin
      if (b_swe) mem_b[b_saddr] <= bmerge(mem_b[b_saddr], b_swd, b_sbe);
      else b_s0 <= mem_b[b_saddr];
    end
    b_srd <= b_s0;
  end

  // ---------------- C: 4 ports, RL=1 ----------------
  logic             c_rst;
  logic [3:0]       c_req, c_gnt, c_we, c_rv;
  logic [3:0][3:0]  c_addr;
  logic [3:0][63:0] c_wd, c_rd;
  logic [3:0][7:0]  c_be;
  logic             c_sreq, c_swe;
  logic [3:0]       c_saddr;
  logic [63:0]      c_swd, c_srd;
  logic [7:0]       c_sbe;
  logic [63:0]      mem_c [16];

  sram_arb #(.NUM_PORTS(4), .DATA_WIDTH(64), .NUM_WORDS(16), .OUT_REGS(0)) u_c (
    .clk_i(clk), .rst_i(c_rst), .req_i(c_req), .gnt_o(c_gnt), .we_i(c_we),
    .addr_i(c_addr), .wdata_i(c_wd), .be_i(c_be), .rvalid_o(c_rv),
    .rdata_o(c_rd), .sram_req_o(c_sreq), .sram_we_o(c_swe),
    .sram_addr_o(c_saddr), .sram_wdata_o(c_swd), .sram_be_o(c_sbe),
    .sram_rdata_i(c_srd));

  always @(posedge clk) if (c_sreq) begin
    if (c_swe) mem_c[c_saddr] <= bmerge(mem_c[c_saddr], c_swd, c_sbe);
    else c_srd <= mem_c[c_saddr];
  end

  // ---------------- vector table for A ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  req, we;
    logic [3:0]  ad0, ad1;
    logic [63:0] wd0, wd1;
    logic [7:0]  be0, be1;
    logic [1:0]  gnt, rv;
    logic [63:0] rd0, rd1;
    logic        sreq, swe;
    logic [3:0]  saddr;
  } vec_t;

  vec_t vt [13];

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
      mem_c[i] = 64'h100 + 64'(i);
    end
    mem_b[3] = 64'h3333_0000_0000_0003;
    mem_b[4] = 64'h4444_0000_0000_0004;

    //          rst  req    we     a0 a1 wd0           wd1       be0    be1    gnt    rv     rd0           rd1  sreq swe saddr
    vt[0]  = '{1'b1, 2'b11, 2'b00, 5, 0, 0,            0,        8'hFF, 8'hFF, 2'b00, 2'b00, 0,            0,    0, 0, 0};
    vt[1]  = '{1'b0, 2'b01, 2'b01, 5, 0, 64'hA5A5,     0,        8'hFF, 8'hFF, 2'b01, 2'b00, 0,            0,    1, 1, 5};
    vt[2]  = '{1'b0, 2'b01, 2'b00, 5, 0, 0,            0,        8'hFF, 8'hFF, 2'b01, 2'b00, 0,            0,    1, 0, 5};
    vt[3]  = '{1'b0, 2'b00, 2'b00, 0, 0, 0,            0,        8'hFF, 8'hFF, 2'b00, 2'b01, 64'hA5A5,     0,    0, 0, 0};
    vt[4]  = '{1'b0, 2'b01, 2'b01, 0, 0, ONES,         0,        8'h01, 8'hFF, 2'b01, 2'b00, 0,            0,    1, 1, 0};
    vt[5]  = '{1'b0, 2'b01, 2'b00, 0, 0, 0,            0,        8'hFF, 8'hFF, 2'b01, 2'b00, 0,            0,    1, 0, 0};
    vt[6]  = '{1'b0, 2'b00, 2'b00, 0, 0, 0,            0,        8'hFF, 8'hFF, 2'b00, 2'b01, 64'hFF,       0,    0, 0, 0};
    vt[7]  = '{1'b0, 2'b11, 2'b00, 5, 0, 0,            0,        8'hFF, 8'hFF, 2'b10, 2'b00, 0,            0,    1, 0, 0};
    vt[8]  = '{1'b0, 2'b11, 2'b00, 5, 0, 0,            0,        8'hFF, 8'hFF, 2'b01, 2'b10, 0,            64'hFF, 1, 0, 5};
    vt[9]  = '{1'b0, 2'b11, 2'b00, 5, 0, 0,            0,        8'hFF, 8'hFF, 2'b10, 2'b01, 64'hA5A5,     0,    1, 0, 0};
    vt[10] = '{1'b0, 2'b10, 2'b10, 0, 7, 0,            64'h1234, 8'hFF, 8'hFF, 2'b10, 2'b10, 0,            64'hFF, 1, 1, 7};
    vt[11] = '{1'b0, 2'b01, 2'b00, 7, 0, 0,            0,        8'hFF, 8'hFF, 2'b01, 2'b00, 0,            0,    1, 0, 7};
    vt[12] = '{1'b0, 2'b00, 2'b00, 0, 0, 0,            0,        8'hFF, 8'hFF, 2'b00, 2'b01, 64'h1234,     0,    0, 0, 0};
  end

  initial begin
    a_rst = 1; b_rst = 1; c_rst = 1;
    a_req = 0; a_we = 0; a_addr = '0; a_wd = '0; a_be = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wd = '0; b_be = '0;
    c_req = 0; c_we = 0; c_addr = '0; c_wd = '0; c_be = '0;
    repeat (2) @(posedge clk);
    b_rst = 0; c_rst = 0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      a_rst = vt[i].rst; a_req = vt[i].req; a_we = vt[i].we;
      a_addr[0] = vt[i].ad0; a_addr[1] = vt[i].ad1;
      a_wd[0] = vt[i].wd0; a_wd[1] = vt[i].wd1;
      a_be[0] = vt[i].be0; a_be[1] = vt[i].be1;
      #1;
      chk($sformatf("a%0d gnt", i), 64'(a_gnt), 64'(vt[i].gnt));
      chk($sformatf("a%0d rvalid", i), 64'(a_rv), 64'(vt[i].rv));
      chk($sformatf("a%0d rdata0", i), a_rd[0], vt[i].rd0);
      chk($sformatf("a%0d rdata1", i), a_rd[1], vt[i].rd1);
      chk($sformatf("a%0d sram_req", i), 64'(a_sreq), 64'(vt[i].sreq));
      chk($sformatf("a%0d sram_we", i), 64'(a_swe), 64'(vt[i].swe));
      chk($sformatf("a%0d sram_addr", i), 64'(a_saddr), 64'(vt[i].saddr));
    end

    // B: back-to-back reads with RL=2, then reset kills an in-flight read
    @(negedge clk); b_req = 2'b10; b_addr[1] = 3; #1;
    chk("b grantA", 64'(b_gnt), 64'b10);
    chk("b rvA", 64'(b_rv), 0);
    @(negedge clk); b_req = 2'b01; b_addr[0] = 4; #1;
    chk("b grantB", 64'(b_gnt), 64'b01);
    chk("b rvB", 64'(b_rv), 0);
    @(negedge clk); b_req = 2'b00; #1;
    chk("b rv+2", 64'(b_rv), 64'b10);
    chk("b rd1+2", b_rd[1], 64'h3333_0000_0000_0003);
    chk("b rd0+2", b_rd[0], 0);
    @(negedge clk); #1;
    chk("b rv+3", 64'(b_rv), 64'b01);
    chk("b rd0+3", b_rd[0], 64'h4444_0000_0000_0004);
    @(negedge clk); #1;
    chk("b rv+4", 64'(b_rv), 0);
    @(negedge clk); b_req = 2'b01; b_addr[0] = 3; #1;
    chk("b grantF", 64'(b_gnt), 64'b01);
    @(negedge clk); b_rst = 1; b_req = 2'b11; #1;
    chk("b rst gnt", 64'(b_gnt), 0);
    chk("b rst sreq", 64'(b_sreq), 0);
    chk("b rst saddr", 64'(b_saddr), 0);
    chk("b rst rv", 64'(b_rv), 0);
    @(negedge clk); b_rst = 0; b_req = 2'b00; #1;
    chk("b killed rv", 64'(b_rv), 0);
    @(negedge clk); b_req = 2'b11; b_addr[0] = 3; b_addr[1] = 4; #1;
    chk("b post-rst gnt", 64'(b_gnt), 64'b01);
    chk("b post-rst rv", 64'(b_rv), 0);
    @(negedge clk); b_req = 2'b00; #1;
    chk("b rv I+1", 64'(b_rv), 0);
    @(negedge clk); #1;
    chk("b rv I+2", 64'(b_rv), 64'b01);
    chk("b rd0 I+2", b_rd[0], 64'h3333_0000_0000_0003);

    // C: four continuous requesters rotate 0,1,2,3
    for (int p = 0; p < 4; p++) c_addr[p] = 4'(p);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      c_req = (i < 9) ? 4'b1111 : 4'b0000;
      #1;
      chk($sformatf("c%0d gnt", i), 64'(c_gnt),
          (i < 9) ? (64'd1 << (i % 4)) : 64'd0);
      chk($sformatf("c%0d rvalid", i), 64'(c_rv),
          (i == 0) ? 64'd0 : (64'd1 << ((i - 1) % 4)));
      if (i > 0)
        chk($sformatf("c%0d rdata", i), c_rd[(i - 1) % 4],
            64'h100 + 64'((i - 1) % 4));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
